aligned_fifo: RTL and testbench
===============================

# aligned_fifo

Width-converting FIFO that packs N narrow input words into one wide output word, with valid/ready flow control on the write side, fixed-latency pop on the read side, and partial-word commit via `wr_last`. Generalised successor to the narrow-write/wide-read aligned RAM: same lane ordering, plus occupancy tracking, backpressure, and per-word lane count. Sits between narrow producers (e.g. 32-bit register/DMA streams) and wide sample-parallel DSP consumers.

## Interface
- `DIN_WIDTH`, 32: narrow (lane) word width.
- `N_DIN_TO_DOUT`, 4: lanes per wide word; power of 2, ≥2.
- `DOUT_ADDR_WIDTH`, 10: depth is 2**DOUT_ADDR_WIDTH wide words.
- `READ_LATENCY`, 2: rd_en-to-rd_valid latency in cycles, ≥1.
- `clk` in 1: sole clock, all logic on rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `wr_data` in DIN_WIDTH: narrow input word.
- `wr_valid` in 1: wr_data/wr_last valid.
- `wr_last` in 1: commit current wide word after this lane; qualified by wr_valid.
- `wr_ready` out 1: accept; equals !full.
- `rd_en` in 1: pop request.
- `rd_data` out N_DIN_TO_DOUT*DIN_WIDTH: wide word; lane i at bits [DIN_WIDTH*(i+1)-1 : DIN_WIDTH*i].
- `rd_lanes` out $clog2(N_DIN_TO_DOUT)+1: number of written lanes in rd_data (1..N).
- `rd_valid` out 1: rd_data/rd_lanes valid, one-cycle pulse per pop.
- `level` out DOUT_ADDR_WIDTH+1: committed wide words stored.
- `full` out 1: level == 2**DOUT_ADDR_WIDTH.
- `empty` out 1: level == 0.
- `underflow` out 1: sticky; set on rd_en while empty; cleared only by reset.

## Operation
- Write accept: wr_valid && wr_ready at a rising edge. wr_valid with wr_ready low: no effect, data not taken; producer holds.
- Assembly register (N lanes) plus lane counter `lane` (0..N-1). Accepted word goes to lane `lane`; lane 0 first, at LSBs.
- Commit when accepted word lands in lane N-1, or accepted with wr_last=1. Commit writes {assembly lanes, lane count = lane+1} into RAM slot wr_ptr; wr_ptr++ (wraps modulo depth); lane and assembly register cleared to 0.
- Partial commit: unwritten lanes above the last one are zero in the stored word. wr_last on lane N-1 is an ordinary full commit (rd_lanes = N).
- wr_last with wr_valid low: ignored.
- Pop: rd_en && !empty at edge: rd_ptr++ (wraps), level--, RAM slot rd_ptr read into READ_LATENCY-deep pipeline. rd_en while empty: no pop, no rd_valid, underflow set.
- Simultaneous commit and pop: level unchanged; both pointers advance.
- Full: wr_ready low, no lanes accepted (including partially filled assembly). Pop at edge t while full → wr_ready high after t.
- Newly committed word not poppable in its commit cycle (empty/level evaluated before edge); poppable from next edge. Read and write never target same slot in one cycle.
- rd_data/rd_lanes hold last popped value when rd_valid low.

## Timing
- Reset (rstn low, async): level=0, full=0, empty=1, wr_ready=1, rd_valid=0, rd_data=0, rd_lanes=0, underflow=0, pointers/lane/assembly 0. In-flight read pipeline discarded. RAM contents not reset.
- Reset release: wr_ready high in first cycle after rstn deasserts.
- Commit at edge t: level/empty/full updated after edge t.
- Pop at edge t: rd_valid high in cycle after edge t+READ_LATENCY-1 (READ_LATENCY=1 → cycle after t). One rd_valid pulse per pop, in pop order; back-to-back pops yield back-to-back rd_valid.
- Throughput: one narrow write per cycle; one wide pop per cycle.
- full/empty/wr_ready derived combinationally from registered level.

## Test plan
- N=4, DIN=32: write 0x11,0x22,0x33,0x44, pop → after READ_LATENCY cycles rd_data=0x00000044_00000033_00000022_00000011, rd_lanes=4, rd_valid one cycle.
- Write 0xA,0xB with wr_last on 0xB, then 0xC..0xF → two words: lanes {0,0,0xB,0xA} rd_lanes=2, then {0xF,0xE,0xD,0xC} rd_lanes=4.
- DOUT_ADDR_WIDTH=2: write 16 lanes → full=1, level=4, wr_ready=0; 17th word held; pop once → wr_ready=1, held word accepted; 4 pops return words in order, pointers wrap.
- Steady state: write every cycle while popping each commit → level oscillates 0/1, no data loss, order preserved across 3 pointer wraps.
- rd_en with empty=1 → no rd_valid, underflow=1 and stays 1 through later traffic until rstn low.
- Assert rstn low with 2 pops in flight and partial lane count 2 → rd_valid never pulses, level=0, empty=1; next 4 writes form lanes 0..3 cleanly.

Source files
------------

// File: rtl/aligned_fifo.sv
// Narrow-write / wide-read FIFO: packs up to N lanes per wide word, with early
// commit on wr_last, occupancy tracking and a fixed-latency registered read path.

module aligned_fifo_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         we,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic [W-1:0] mrg
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= din;
    end

    // Lane content as it will be committed this cycle, including the word being accepted.
    assign mrg = we ? din : q;
endmodule

module aligned_fifo #(
    parameter int DIN_WIDTH       = 32,
    parameter int N_DIN_TO_DOUT   = 4,
    parameter int DOUT_ADDR_WIDTH = 10,
    parameter int READ_LATENCY    = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [DIN_WIDTH-1:0]                 wr_data,
    input  logic                                 wr_valid,
    input  logic                                 wr_last,
    output logic                                 wr_ready,
    input  logic                                 rd_en,
    output logic [N_DIN_TO_DOUT*DIN_WIDTH-1:0]   rd_data,
    output logic [$clog2(N_DIN_TO_DOUT):0]       rd_lanes,
    output logic                                 rd_valid,
    output logic [DOUT_ADDR_WIDTH:0]             level,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 underflow
);
    localparam int N     = N_DIN_TO_DOUT;
    localparam int LW    = $clog2(N);
    localparam int CW    = LW + 1;
    localparam int AW    = DOUT_ADDR_WIDTH;
    localparam int DW    = N * DIN_WIDTH;
    localparam int EW    = DW + CW;
    localparam int L     = READ_LATENCY;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_L   = {{AW{1'b0}}, 1'b1};

    logic [LW-1:0]                    lane_q;
    logic [N-1:0][DIN_WIDTH-1:0]      asm_q, asm_mrg;
    logic [AW-1:0]                    wr_ptr, rd_ptr;
    logic [AW:0]                      level_q;
    logic                             accept, commit, pop;
    logic [CW-1:0]                    lane_cnt;
    logic [EW-1:0]                    mem [DEPTH];
    logic [EW-1:0]                    dat_pipe [1:L];
    logic [L:1]                       vld_pipe;

    assign full     = (level_q == DEPTH_L);
    assign empty    = (level_q == '0);
    assign wr_ready = !full;
    assign level    = level_q;
    assign accept   = wr_valid && wr_ready;
    assign commit   = accept && (wr_last || lane_q == LW'(N - 1));
    assign pop      = rd_en && !empty;
    assign lane_cnt = CW'(lane_q) + CW'(1);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            aligned_fifo_lane #(.W(DIN_WIDTH)) u_lane (
                .clk  (clk),
                .rstn (rstn),
                .we   (accept && lane_q == LW'(i)),
                .clr  (commit),
                .din  (wr_data),
                .q    (asm_q[i]),
                .mrg  (asm_mrg[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_q    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            underflow <= 1'b0;
        end else begin
            if (commit)      lane_q <= '0;
            else if (accept) lane_q <= lane_q + LW'(1);
            if (commit) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({commit, pop})
                2'b10:   level_q <= level_q + ONE_L;
                2'b01:   level_q <= level_q - ONE_L;
                default: level_q <= level_q;
            endcase
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    // Storage is not reset; unwritten upper lanes are already zero in asm_q.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr] <= {lane_cnt, asm_mrg};
    end

    // Each stage only loads behind a valid, so the last stage holds the last popped word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            for (int k = 1; k <= L; k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[1] <= pop;
            if (pop) dat_pipe[1] <= mem[rd_ptr];
            for (int k = 2; k <= L; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign rd_valid = vld_pipe[L];
    assign rd_data  = dat_pipe[L][DW-1:0];
    assign rd_lanes = dat_pipe[L][EW-1:DW];

    logic unused_ok;
    assign unused_ok = ^asm_q;
endmodule

// File: tb/tb_aligned_fifo.sv
// Bench for aligned_fifo: directed scenarios plus random traffic, checked each
// cycle against a queue-based model of committed words and pending pops.

module tb_aligned_fifo;
    localparam int W     = 32;
    localparam int N     = 4;
    localparam int AW    = 2;
    localparam int L     = 2;
    localparam int DEPTH = 4;
    localparam int DW    = N * W;
    localparam int CW    = 3;

    typedef struct packed {
        logic [CW-1:0] lanes;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  wr_data;
    logic          wr_valid, wr_last, wr_ready, rd_en;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] rd_lanes;
    logic          rd_valid, full, empty, underflow;
    logic [AW:0]   level;

    aligned_fifo #(
        .DIN_WIDTH(W), .N_DIN_TO_DOUT(N), .DOUT_ADDR_WIDTH(AW), .READ_LATENCY(L)
    ) dut (
        .clk(clk), .rstn(rstn), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_last(wr_last), .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data),
        .rd_lanes(rd_lanes), .rd_valid(rd_valid), .level(level), .full(full),
        .empty(empty), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model
    logic [DW-1:0] m_cur;
    int            m_lane;
    word_t         mq[$];
    bit            m_uf;
    int            pend_due[$];
    word_t         pend_w[$];
    word_t         m_last;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cur = '0; m_lane = 0; mq.delete(); m_uf = 0;
        pend_due.delete(); pend_w.delete(); m_last = '0;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit last, input bit r);
        wr_valid = v; wr_data = d; wr_last = last; rd_en = r;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (pend_due.size() > 0) && (pend_due[0] == cyc);
        if (ev) begin
            void'(pend_due.pop_front());
            m_last = pend_w.pop_front();
        end
        chk("rd_valid", DW'(rd_valid), DW'(ev));
        chk("rd_data", rd_data, m_last.data);
        chk("rd_lanes", DW'(rd_lanes), DW'(m_last.lanes));
        chk("level", DW'(level), DW'(mq.size()));
        chk("full", DW'(full), DW'(mq.size() == DEPTH));
        chk("empty", DW'(empty), DW'(mq.size() == 0));
        chk("wr_ready", DW'(wr_ready), DW'(mq.size() != DEPTH));
        chk("underflow", DW'(underflow), DW'(m_uf));
    endtask

    // One clock: predict effects of the current inputs, step, then compare.
    task automatic cycle();
        bit acc, pop;
        word_t w;
        acc = wr_valid && (mq.size() < DEPTH);
        pop = rd_en && (mq.size() > 0);
        if (rd_en && mq.size() == 0) m_uf = 1;
        if (pop) begin
            pend_w.push_back(mq.pop_front());
            pend_due.push_back(cyc + L);
        end
        if (acc) begin
            m_cur[m_lane*W +: W] = wr_data;
            if (m_lane == N - 1 || wr_last) begin
                w.data  = m_cur;
                w.lanes = CW'(m_lane + 1);
                mq.push_back(w);
                m_cur  = '0;
                m_lane = 0;
            end else begin
                m_lane++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0);
        rstn = 1'b0;
        model_clear();
        #2;
        chk("rst_rd_valid", DW'(rd_valid), '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_lanes", DW'(rd_lanes), '0);
        chk("rst_level", DW'(level), '0);
        chk("rst_empty", DW'(empty), DW'(1));
        chk("rst_full", DW'(full), '0);
        chk("rst_underflow", DW'(underflow), '0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        chk("rel_wr_ready", DW'(wr_ready), DW'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) begin
            drive(0, '0, 0, mq.size() > 0);
            cycle();
        end
        drive(0, '0, 0, 0);
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, '0, 0, 0);
        model_clear();
        #1;
        do_reset();
        cycle();

        // four full lanes, one pop
        drive(1, 32'h11, 0, 0); cycle();
        drive(1, 32'h22, 0, 0); cycle();
        drive(1, 32'h33, 0, 0); cycle();
        drive(1, 32'h44, 0, 0); cycle();
        drive(0, '0, 0, 1); cycle();
        drive(0, '0, 0, 0); cycle();
        chk("tp1_valid", DW'(rd_valid), DW'(1));
        chk("tp1_data", rd_data, 128'h00000044_00000033_00000022_00000011);
        chk("tp1_lanes", DW'(rd_lanes), DW'(4));
        cycle();

        // partial commit followed by a full word
        drive(1, 32'hA, 0, 0); cycle();
        drive(1, 32'hB, 1, 0); cycle();
        drive(0, 32'hEE, 1, 0); cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1, W'(32'hC + k), 0, 0); cycle();
        end
        drive(0, '0, 0, 1); cycle();
        drive(0, '0, 0, 1); cycle();
        chk("tp2_data", rd_data, 128'h0000000B_0000000A);
        chk("tp2_lanes", DW'(rd_lanes), DW'(2));
        drive(0, '0, 0, 0); cycle();
        chk("tp2b_data", rd_data, 128'h0000000F_0000000E_0000000D_0000000C);
        cycle(); cycle();

        // fill to full, hold the 17th word, release with one pop
        for (int k = 0; k < 16; k++) begin
            drive(1, W'(32'h100 + k), 0, 0); cycle();
        end
        chk("full_flag", DW'(full), DW'(1));
        drive(1, 32'h1FF, 0, 0); cycle(); cycle();
        drive(1, 32'h1FF, 0, 1); cycle();
        chk("full_release", DW'(wr_ready), DW'(1));
        drive(1, 32'h1FF, 0, 0); cycle();
        drain();

        // steady state streaming across several pointer wraps
        for (int k = 0; k < 64; k++) begin
            drive(1, $urandom, 0, mq.size() > 0); cycle();
        end
        drain();

        // random traffic
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 2) == 0) && (mq.size() > 0));
            cycle();
        end
        drain();

        // underflow is sticky through further traffic
        drive(0, '0, 0, 1); cycle();
        chk("uf_set", DW'(underflow), DW'(1));
        for (int k = 0; k < 60; k++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0);
            cycle();
        end
        drain();

        // reset with pops in flight and a partially assembled word
        for (int k = 0; k < 12; k++) begin
            drive(1, $urandom, 0, 0); cycle();
        end
        drive(1, 32'hDEAD, 0, 0); cycle();
        drive(1, 32'hBEEF, 0, 0); cycle();
        drive(0, '0, 0, 1); cycle();
        drive(0, '0, 0, 1); cycle();
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1, W'(32'h50 + k), 0, 0); cycle();
        end
        drive(0, '0, 0, 1); cycle();
        drive(0, '0, 0, 0); cycle();
        chk("post_rst_data", rd_data, 128'h00000053_00000052_00000051_00000050);
        chk("post_rst_lanes", DW'(rd_lanes), DW'(4));
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
